// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - checks a combinational DUT's 1-bit response against an expected truth table
// Vectors must arrive in ascending order; the run ends when the all-ones vector has been sampled.
module truth_table_checker #(
  parameter int                     N_IN   = 4,
  parameter logic [(2**N_IN)-1:0]   EXP_TT = '0,
  parameter int                     SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [N_IN-1:0] vec_in,
  input  logic            dut_out,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid,
  output logic            seq_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  logic [1:0]      state;
  logic [N_IN-1:0] exp_idx;
  logic [N_IN-1:0] cur_vec;
  logic [7:0]      settle_cnt;
  logic            mismatch;

  assign vec_ready = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == '0) && !seq_err;

  // Case inequality so an X/Z response is counted as a failure in simulation.
  assign mismatch  = (dut_out !== EXP_TT[cur_vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      exp_idx          <= '0;
      cur_vec          <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      seq_err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_RUN;
            exp_idx          <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            seq_err          <= 1'b0;
          end
        end
        S_RUN: begin
          if (vec_valid) begin
            cur_vec    <= vec_in;
            settle_cnt <= SETTLE_CNT;
            state      <= S_WAIT;
            if (vec_in != exp_idx) seq_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end else begin
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (!first_fail_valid) begin
                first_fail_vec   <= cur_vec;
                first_fail_valid <= 1'b1;
              end
            end
            exp_idx <= cur_vec + 1'b1;
            state   <= (&cur_vec) ? S_DONE : S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized self-checking bench for truth_table_checker
// Instance a uses SETTLE=0, instance b uses SETTLE=2; both expect a 4-input XOR.
module tb_truth_table_checker;

  localparam logic [15:0] TT = 16'h6996;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_vec_valid = 1'b0, a_dut_out = 1'b0;
  logic [3:0] a_vec_in = 4'd0;
  logic       a_vec_ready, a_done, a_pass, a_ffv, a_seq_err;
  logic [4:0] a_err_count;
  logic [3:0] a_ff_vec;

  logic       b_start = 1'b0, b_vec_valid = 1'b0, b_dut_out = 1'b0;
  logic [3:0] b_vec_in = 4'd0;
  logic       b_vec_ready, b_done, b_pass, b_ffv, b_seq_err;
  logic [4:0] b_err_count;
  logic [3:0] b_ff_vec;

  truth_table_checker #(.N_IN(4), .EXP_TT(TT), .SETTLE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .vec_valid(a_vec_valid), .vec_ready(a_vec_ready),
    .vec_in(a_vec_in), .dut_out(a_dut_out), .done(a_done), .pass(a_pass), .err_count(a_err_count),
    .first_fail_vec(a_ff_vec), .first_fail_valid(a_ffv), .seq_err(a_seq_err)
  );

  truth_table_checker #(.N_IN(4), .EXP_TT(TT), .SETTLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .vec_valid(b_vec_valid), .vec_ready(b_vec_ready),
    .vec_in(b_vec_in), .dut_out(b_dut_out), .done(b_done), .pass(b_pass), .err_count(b_err_count),
    .first_fail_vec(b_ff_vec), .first_fail_valid(b_ffv), .seq_err(b_seq_err)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus for one run and the verdict the rules predict for it.
  logic [3:0] vecs[$];
  logic       bads[$];
  int         exp_err;
  logic [3:0] exp_ff;
  logic       exp_ffv, exp_seq, exp_pass;

  task automatic model();
    logic [15:0] tt_v;
    logic [3:0]  nxt;
    logic        got;
    tt_v = TT;
    nxt = 4'd0;
    exp_err = 0; exp_ff = 4'd0; exp_ffv = 1'b0; exp_seq = 1'b0;
    foreach (vecs[i]) begin
      got = (^vecs[i]) ^ bads[i];
      if (got != tt_v[vecs[i]]) begin
        exp_err++;
        if (!exp_ffv) begin exp_ffv = 1'b1; exp_ff = vecs[i]; end
      end
      if (vecs[i] != nxt) exp_seq = 1'b1;
      nxt = vecs[i] + 4'd1;
    end
    exp_pass = (exp_err == 0) && !exp_seq;
  endtask

  // Every driver task starts and ends just after a falling edge.
  task automatic pulse_start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic send_a(input logic [3:0] v, input logic bad);
    int n;
    a_vec_in = v; a_dut_out = (^v) ^ bad; a_vec_valid = 1'b1;
    n = 0;
    while (!a_vec_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!a_vec_ready) begin
      errors++;
      $display("FAIL send_a_accept vec %0d: vec_ready stayed %b, required 1", v, a_vec_ready);
      a_vec_valid = 1'b0;
      return;
    end
    @(negedge clk);
    a_vec_valid = 1'b0;
    n = 0;
    while (!a_vec_ready && !a_done && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic run_a();
    pulse_start_a();
    foreach (vecs[i]) send_a(vecs[i], bads[i]);
    model();
  endtask

  task automatic fill_seq(input int skip);
    vecs.delete(); bads.delete();
    for (int i = 0; i < 16; i++) if (i != skip) begin vecs.push_back(4'(i)); bads.push_back(1'b0); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (a_vec_ready !== 1'b0) begin errors++; $display("FAIL reset_vec_ready got %b exp 0", a_vec_ready); end
    checks++; if (a_done !== 1'b0 || a_pass !== 1'b0) begin errors++; $display("FAIL reset_done_pass got %b%b exp 00", a_done, a_pass); end
    checks++; if (a_err_count !== 5'd0 || a_ff_vec !== 4'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", a_err_count, a_ff_vec); end
    checks++; if (a_ffv !== 1'b0 || a_seq_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", a_ffv, a_seq_err); end
    checks++; if (b_vec_ready !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b got %b%b exp 00", b_vec_ready, b_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_vec_ready !== 1'b0) begin errors++; $display("FAIL idle_vec_ready got %b exp 0", a_vec_ready); end
  endtask

  task automatic test_clean();
    fill_seq(-1);
    run_a();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL clean_done got %b exp 1", a_done); end
    checks++; if (a_pass !== exp_pass) begin errors++; $display("FAIL clean_pass got %b exp %b", a_pass, exp_pass); end
    checks++; if (a_err_count !== 5'(exp_err)) begin errors++; $display("FAIL clean_err_count got %0d exp %0d", a_err_count, exp_err); end
    checks++; if (a_seq_err !== exp_seq || a_ffv !== exp_ffv) begin errors++; $display("FAIL clean_flags got %b%b exp %b%b", a_seq_err, a_ffv, exp_seq, exp_ffv); end
    checks++; if (a_vec_ready !== 1'b0) begin errors++; $display("FAIL done_vec_ready got %b exp 0", a_vec_ready); end
  endtask

  task automatic test_two_errors();
    fill_seq(-1);
    bads[5] = 1'b1; bads[9] = 1'b1;
    run_a();
    checks++; if (a_err_count !== 5'(exp_err)) begin errors++; $display("FAIL two_err_count got %0d exp %0d", a_err_count, exp_err); end
    checks++; if (a_ff_vec !== exp_ff || a_ffv !== exp_ffv) begin errors++; $display("FAIL two_first_fail got %0d/%b exp %0d/%b", a_ff_vec, a_ffv, exp_ff, exp_ffv); end
    checks++; if (a_pass !== exp_pass || a_done !== 1'b1) begin errors++; $display("FAIL two_verdict got pass %b done %b exp pass %b done 1", a_pass, a_done, exp_pass); end
  endtask

  task automatic test_skip();
    fill_seq(3);
    run_a();
    checks++; if (a_seq_err !== exp_seq) begin errors++; $display("FAIL skip_seq_err got %b exp %b", a_seq_err, exp_seq); end
    checks++; if (a_err_count !== 5'(exp_err)) begin errors++; $display("FAIL skip_err_count got %0d exp %0d", a_err_count, exp_err); end
    checks++; if (a_pass !== exp_pass || a_done !== 1'b1) begin errors++; $display("FAIL skip_verdict got pass %b done %b exp pass %b done 1", a_pass, a_done, exp_pass); end
  endtask

  task automatic test_random();
    logic [3:0] nxt;
    logic [3:0] v;
    for (int run = 0; run < 8; run++) begin
      vecs.delete(); bads.delete();
      nxt = 4'd0;
      for (int i = 0; i < 40; i++) begin
        v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : nxt;
        if (i == 39) v = 4'hF;
        vecs.push_back(v);
        bads.push_back($urandom_range(0, 4) == 0);
        if (v == 4'hF) break;
        nxt = v + 4'd1;
      end
      run_a();
      checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rand%0d_done got %b exp 1", run, a_done); end
      checks++; if (a_err_count !== 5'(exp_err)) begin errors++; $display("FAIL rand%0d_err_count got %0d exp %0d", run, a_err_count, exp_err); end
      checks++; if (a_ffv !== exp_ffv || (exp_ffv && a_ff_vec !== exp_ff)) begin errors++; $display("FAIL rand%0d_first_fail got %0d/%b exp %0d/%b", run, a_ff_vec, a_ffv, exp_ff, exp_ffv); end
      checks++; if (a_seq_err !== exp_seq) begin errors++; $display("FAIL rand%0d_seq_err got %b exp %b", run, a_seq_err, exp_seq); end
      checks++; if (a_pass !== exp_pass) begin errors++; $display("FAIL rand%0d_pass got %b exp %b", run, a_pass, exp_pass); end
    end
  endtask

  task automatic test_start_ignored();
    fill_seq(-1);
    bads[2] = 1'b1;
    model();
    pulse_start_a();
    for (int i = 0; i < 6; i++) send_a(vecs[i], bads[i]);
    pulse_start_a();
    checks++; if (a_err_count !== 5'd1 || a_ffv !== 1'b1 || a_ff_vec !== 4'd2) begin errors++; $display("FAIL ignored_start_counts got %0d/%b/%0d exp 1/1/2", a_err_count, a_ffv, a_ff_vec); end
    checks++; if (a_vec_ready !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL ignored_start_state got ready %b done %b exp 1 0", a_vec_ready, a_done); end
    for (int i = 6; i < 16; i++) send_a(vecs[i], bads[i]);
    checks++; if (a_err_count !== 5'(exp_err) || a_pass !== exp_pass) begin errors++; $display("FAIL ignored_final got %0d/%b exp %0d/%b", a_err_count, a_pass, exp_err, exp_pass); end
    pulse_start_a();
    checks++; if (a_done !== 1'b0 || a_err_count !== 5'd0 || a_ffv !== 1'b0) begin errors++; $display("FAIL restart_clear got done %b err %0d ffv %b exp 0 0 0", a_done, a_err_count, a_ffv); end
    checks++; if (a_vec_ready !== 1'b1) begin errors++; $display("FAIL restart_vec_ready got %b exp 1", a_vec_ready); end
  endtask

  task automatic test_async_reset();
    vecs.delete(); bads.delete();
    foreach (vecs[i]) vecs.delete(i);
    for (int i = 0; i < 7; i++) if (i != 4) begin vecs.push_back(4'(i)); bads.push_back(i == 3); end
    run_a();
    checks++; if (a_err_count !== 5'(exp_err) || a_seq_err !== exp_seq) begin errors++; $display("FAIL pre_reset got err %0d seq %b exp %0d %b", a_err_count, a_seq_err, exp_err, exp_seq); end
    a_vec_in = 4'd7; a_dut_out = 1'b1; a_vec_valid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a_err_count !== 5'd0 || a_ffv !== 1'b0 || a_ff_vec !== 4'd0 || a_seq_err !== 1'b0) begin errors++; $display("FAIL async_reset_results got %0d/%b/%0d/%b exp 0/0/0/0", a_err_count, a_ffv, a_ff_vec, a_seq_err); end
    checks++; if (a_vec_ready !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin errors++; $display("FAIL async_reset_status got %b%b%b exp 000", a_vec_ready, a_done, a_pass); end
    a_vec_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_seq(-1);
    run_a();
    checks++; if (a_pass !== 1'b1 || a_done !== 1'b1) begin errors++; $display("FAIL post_reset_run got pass %b done %b exp 1 1", a_pass, a_done); end
  endtask

  task automatic test_settle();
    longint t_start, edges;
    int n, low;
    logic [3:0] v;
    b_start = 1'b1;
    @(posedge clk);
    t_start = $time;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      b_vec_in = v; b_dut_out = ^v; b_vec_valid = 1'b1;
      n = 0;
      while (!b_vec_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      b_vec_valid = 1'b0;
      b_dut_out = ~(^v);
      low = 0;
      while (!b_vec_ready && !b_done && low < 20) begin
        low++;
        if (low == 3) b_dut_out = ^v;
        @(negedge clk);
      end
      checks++; if (low != 3) begin errors++; $display("FAIL settle_ready_low vec %0d got %0d cycles exp 3", i, low); end
    end
    edges = ($time - t_start - 5) / 10;
    checks++; if (b_done !== 1'b1 || edges != 64) begin errors++; $display("FAIL settle_run_length got done %b after %0d edges exp 1 after 64", b_done, edges); end
    checks++; if (b_err_count !== 5'd0 || b_pass !== 1'b1) begin errors++; $display("FAIL settle_verdict got err %0d pass %b exp 0 1", b_err_count, b_pass); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_two_errors();
    test_skip();
    test_random();
    test_start_ignored();
    test_async_reset();
    test_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
